// File: rtl/jogo_pkg.sv
// Shared definitions for the play-capture unit: state encodings and default board size.
package jogo_pkg;

    localparam int N_BOTOES_PADRAO = 9;
    localparam int IDX_W_PADRAO    = 4;

    typedef enum logic [2:0] {
        OCIOSO        = 3'd0,
        ESPERA_SOLTAR = 3'd1,
        ARMADO        = 3'd2,
        VALIDA        = 3'd3,
        ESPERA_LIBERA = 3'd4
    } estado_t;

    // Idle counter width; keeps at least one bit when the timeout is disabled (0).
    function automatic int largura_contador(input int ciclos);
        return (ciclos < 1) ? 1 : $clog2(ciclos + 1);
    endfunction

endpackage

// File: rtl/captura_jogada_detector_borda.sv
// Button front end: 2-flop synchroniser per bit, optional debounce (DEBOUNCE_EN), rising-edge detect.
// Outputs the settled level vector and a one-cycle rising-edge vector.
module detector_borda #(
    parameter int N          = 9,
    parameter int DEB_CICLOS = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] botoes,
    output logic [N-1:0] nivel,
    output logic [N-1:0] borda
);

    logic [N-1:0] sync1_q, sync1_d;
    logic [N-1:0] sync2_q, sync2_d;
    logic [N-1:0] prev_q,  prev_d;

    always_comb begin
        sync1_d = botoes;
        sync2_d = sync1_q;
        prev_d  = nivel;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int DEB_W = (DEB_CICLOS < 2) ? 1 : $clog2(DEB_CICLOS);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_filtro
            logic [DEB_W-1:0] cnt_q, cnt_d;
            logic             filt_q, filt_d;

            // Any sample agreeing with the filtered value restarts the stability count.
            always_comb begin
                filt_d = filt_q;
                cnt_d  = '0;
                if (sync2_q[gi] != filt_q) begin
                    if (cnt_q == DEB_W'(DEB_CICLOS - 1)) begin
                        filt_d = sync2_q[gi];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    cnt_q  <= '0;
                    filt_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    filt_q <= filt_d;
                end
            end

            assign nivel[gi] = filt_q;
        end
    endgenerate
`else
    assign nivel = sync2_q;

    generate
        if (DEB_CICLOS < 1) begin : g_deb_sem_filtro
        end
    endgenerate
`endif

    assign borda = nivel & ~prev_q;

endmodule

// File: rtl/captura_jogada.sv
// Play capture between board buttons and the game FSM; optional button debounce via DEBOUNCE_EN.
// Accepts one fresh single-button press on a free position and holds it until consumed.
module captura_jogada
    import jogo_pkg::*;
#(
    parameter int N_BOTOES       = N_BOTOES_PADRAO,
    parameter int IDX_W          = IDX_W_PADRAO,
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int DEB_CICLOS     = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                habilitar,
    input  logic [N_BOTOES-1:0] ocupadas,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                consumir,
    output logic                jogada_valida,
    output logic [IDX_W-1:0]    jogada,
    output logic [N_BOTOES-1:0] jogada_onehot,
    output logic                jogada_invalida,
    output logic                timeout,
    output logic [2:0]          db_estado
);

    localparam int CNT_W = largura_contador(TIMEOUT_CICLOS);

    logic [N_BOTOES-1:0] nivel;
    logic [N_BOTOES-1:0] borda;

    detector_borda #(
        .N          (N_BOTOES),
        .DEB_CICLOS (DEB_CICLOS)
    ) u_detector (
        .clock  (clock),
        .reset  (reset),
        .botoes (botoes),
        .nivel  (nivel),
        .borda  (borda)
    );

    // Clearing the lowest set bit leaves something only if two or more edges arrived together.
    logic            borda_multipla;
    logic            borda_ocupada;
    logic [IDX_W-1:0] indice;

    always_comb begin
        borda_multipla = |(borda & (borda - 1'b1));
        borda_ocupada  = |(borda & ocupadas);
        indice         = '0;
        for (int i = 0; i < N_BOTOES; i++) begin
            if (borda[i]) begin
                indice = IDX_W'(i);
            end
        end
    end

    estado_t                estado_q,   estado_d;
    logic [IDX_W-1:0]       jogada_q,   jogada_d;
    logic [N_BOTOES-1:0]    onehot_q,   onehot_d;
    logic                   invalida_q, invalida_d;
    logic                   timeout_q,  timeout_d;
    logic [CNT_W-1:0]       cnt_q,      cnt_d;

    always_comb begin
        estado_d   = estado_q;
        jogada_d   = jogada_q;
        onehot_d   = onehot_q;
        invalida_d = 1'b0;
        timeout_d  = 1'b0;
        cnt_d      = '0;

        if (!habilitar) begin
            estado_d = OCIOSO;
        end else begin
            unique case (estado_q)
                OCIOSO: begin
                    estado_d = ESPERA_SOLTAR;
                end
                ESPERA_SOLTAR: begin
                    if (nivel == '0) begin
                        estado_d = ARMADO;
                    end
                end
                ARMADO: begin
                    if (borda_multipla || (|borda && borda_ocupada)) begin
                        invalida_d = 1'b1;
                        estado_d   = ESPERA_SOLTAR;
                    end else if (|borda) begin
                        jogada_d = indice;
                        onehot_d = borda;
                        estado_d = VALIDA;
                    end else if (TIMEOUT_CICLOS != 0) begin
                        // A press on the limit cycle wins above, so no pulse is lost or doubled.
                        if (cnt_q == CNT_W'(TIMEOUT_CICLOS - 1)) begin
                            timeout_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                VALIDA: begin
                    if (consumir) begin
                        estado_d = ESPERA_LIBERA;
                    end
                end
                ESPERA_LIBERA: begin
                    if (nivel == '0) begin
                        estado_d = ARMADO;
                    end
                end
                default: begin
                    estado_d = OCIOSO;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            jogada_q   <= '0;
            onehot_q   <= '0;
            invalida_q <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            estado_q   <= estado_d;
            jogada_q   <= jogada_d;
            onehot_q   <= onehot_d;
            invalida_q <= invalida_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    assign jogada_valida   = (estado_q == VALIDA);
    assign jogada          = jogada_q;
    assign jogada_onehot   = jogada_valida ? onehot_q : '0;
    assign jogada_invalida = invalida_q;
    assign timeout         = timeout_q;
    assign db_estado       = estado_q;

endmodule

// File: tb/tb_captura_jogada.sv
// Directed plus randomized bench for captura_jogada against a sample-history reference model.
module tb_captura_jogada;

    localparam int N  = 9;
    localparam int IW = 4;
    localparam int TO = 8;

    localparam int F_OCIOSO = 0, F_SOLTAR = 1, F_ARMADO = 2, F_VALIDA = 3, F_LIBERA = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          habilitar;
    logic [N-1:0]  ocupadas;
    logic [N-1:0]  botoes;
    logic          consumir;
    logic          jogada_valida;
    logic [IW-1:0] jogada;
    logic [N-1:0]  jogada_onehot;
    logic          jogada_invalida;
    logic          timeout;
    logic [2:0]    db_estado;

    captura_jogada #(
        .N_BOTOES       (N),
        .IDX_W          (IW),
        .TIMEOUT_CICLOS (TO),
        .DEB_CICLOS     (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .habilitar       (habilitar),
        .ocupadas        (ocupadas),
        .botoes          (botoes),
        .consumir        (consumir),
        .jogada_valida   (jogada_valida),
        .jogada          (jogada),
        .jogada_onehot   (jogada_onehot),
        .jogada_invalida (jogada_invalida),
        .timeout         (timeout),
        .db_estado       (db_estado)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int inv_seen, to_seen, valid_seen;

    // Reference model: button samples taken at the last three edges, plus the play phase.
    logic [N-1:0] h1, h2, h3;
    int m_fase, m_idx, m_idle;
    bit m_inv, m_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_tick();
        logic [N-1:0] lvl, e;
        int n;
        m_inv = 0;
        m_to  = 0;
        if (reset) begin
            h1 = '0; h2 = '0; h3 = '0;
            m_fase = F_OCIOSO; m_idx = 0; m_idle = 0;
            return;
        end
        lvl = h2;
        e   = h2 & ~h3;
        n   = $countones(e);
        if (!habilitar) begin
            m_fase = F_OCIOSO;
        end else begin
            case (m_fase)
                F_OCIOSO: m_fase = F_SOLTAR;
                F_SOLTAR: if (lvl == 0) begin m_fase = F_ARMADO; m_idle = 0; end
                F_ARMADO: begin
                    if (n >= 2 || (n == 1 && (e & ocupadas) != 0)) begin
                        m_inv = 1; m_fase = F_SOLTAR;
                    end else if (n == 1) begin
                        for (int i = 0; i < N; i++) if (e[i]) m_idx = i;
                        m_fase = F_VALIDA;
                    end else begin
                        m_idle++;
                        if (m_idle == TO) begin m_to = 1; m_idle = 0; end
                    end
                end
                F_VALIDA: if (consumir) m_fase = F_LIBERA;
                F_LIBERA: if (lvl == 0) begin m_fase = F_ARMADO; m_idle = 0; end
                default:  m_fase = F_OCIOSO;
            endcase
        end
        h3 = h2; h2 = h1; h1 = botoes;
    endtask

    task automatic step();
        logic [N-1:0] exp_oh;
        @(posedge clock);
        model_tick();
        #1;
        exp_oh = '0;
        if (m_fase == F_VALIDA) exp_oh[m_idx] = 1'b1;
        chk("db_estado", 32'(db_estado), 32'(m_fase));
        chk("jogada_valida", 32'(jogada_valida), 32'(m_fase == F_VALIDA));
        chk("jogada_onehot", 32'(jogada_onehot), 32'(exp_oh));
        chk("jogada_invalida", 32'(jogada_invalida), 32'(m_inv));
        chk("timeout", 32'(timeout), 32'(m_to));
        if (m_fase == F_VALIDA) chk("jogada", 32'(jogada), 32'(m_idx));
        inv_seen   += int'(jogada_invalida);
        to_seen    += int'(timeout);
        valid_seen += int'(jogada_valida);
    endtask

    initial begin
        bit armed;
        reset = 1'b1; habilitar = 1'b0; ocupadas = '0; botoes = '0; consumir = 1'b0;
        inv_seen = 0; to_seen = 0; valid_seen = 0;

        // Reset state and arming
        step();
        chk("reset_jogada", 32'(jogada), 32'd0);
        chk("reset_estado", 32'(db_estado), 32'd0);
        reset = 1'b0; habilitar = 1'b1;
        step();
        chk("arm_estado1", 32'(db_estado), 32'd1);
        step();
        chk("arm_estado2", 32'(db_estado), 32'd2);

        // Free single press, held until consumed
        botoes = 9'b000001000;
        step(); step();
        botoes = '0;
        repeat (4) step();
        chk("play_valid", 32'(jogada_valida), 32'd1);
        chk("play_idx", 32'(jogada), 32'd3);
        chk("play_onehot", 32'(jogada_onehot), 32'h008);
        consumir = 1'b1;
        step();
        consumir = 1'b0;
        chk("consume_estado", 32'(db_estado), 32'd4);
        chk("consume_valid", 32'(jogada_valida), 32'd0);
        step();
        chk("release_estado", 32'(db_estado), 32'd2);

        // Occupied position
        ocupadas = 9'b000010000;
        inv_seen = 0; valid_seen = 0;
        botoes = 9'b000010000;
        step(); step();
        botoes = '0;
        step();
        chk("occ_pulse", 32'(jogada_invalida), 32'd1);
        chk("occ_estado", 32'(db_estado), 32'd1);
        repeat (3) step();
        chk("occ_pulse_count", 32'(inv_seen), 32'd1);
        chk("occ_no_valid", 32'(valid_seen), 32'd0);
        ocupadas = '0;

        // Two buttons on the same cycle, then a button held across arming
        inv_seen = 0;
        botoes = 9'b000000110;
        step(); step();
        botoes = '0;
        step();
        chk("multi_pulse", 32'(jogada_invalida), 32'd1);
        repeat (3) step();
        chk("multi_pulse_count", 32'(inv_seen), 32'd1);
        habilitar = 1'b0;
        botoes = 9'b000000010;
        repeat (4) step();
        habilitar = 1'b1;
        valid_seen = 0;
        repeat (8) step();
        chk("held_no_play", 32'(valid_seen), 32'd0);
        chk("held_estado", 32'(db_estado), 32'd1);

        // Timeout cadence from the arming cycle
        botoes = '0;
        armed = 1'b0;
        for (int k = 0; k < 10 && !armed; k++) begin
            step();
            armed = (db_estado == 3'd2);
        end
        chk("arm_bound", 32'(armed), 32'd1);
        to_seen = 0;
        repeat (3 * TO) step();
        chk("timeout_count", 32'(to_seen), 32'd3);

        // Abort from VALIDA
        botoes = 9'b000000001;
        step(); step();
        botoes = '0;
        step(); step();
        chk("abort_pre_valid", 32'(jogada_valida), 32'd1);
        chk("abort_pre_idx", 32'(jogada), 32'd0);
        habilitar = 1'b0;
        step();
        chk("abort_valid", 32'(jogada_valida), 32'd0);
        chk("abort_estado", 32'(db_estado), 32'd0);
        habilitar = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0, 1:    botoes = '0;
                    2:       botoes = N'(1) << $urandom_range(0, N - 1);
                    default: botoes = (N'(1) << $urandom_range(0, N - 1)) | (N'(1) << $urandom_range(0, N - 1));
                endcase
            end
            if (habilitar) habilitar = ($urandom_range(0, 39) != 0);
            else           habilitar = ($urandom_range(0, 3) == 0);
            consumir = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 31) == 0) ocupadas = N'($urandom) & N'($urandom);
            reset = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
